// File: rtl/division_ctrl_if.sv
// Config and divider-side signals of the division_ctrl sequencer.
// master: config source plus divider; slave: the sequencer itself.
interface division_ctrl_if #(
  parameter int RATIO_W = 5,
  parameter int CNT_W   = 4
);
  logic               cfg_valid;
  logic [RATIO_W-1:0] cfg_ratio;
  logic               cfg_ready;
  logic               cfg_err;
  logic [CNT_W-1:0]   div_cnt;
  logic               div_en;
  logic [RATIO_W-1:0] div_ratio;
  logic               div_load;

  modport master (
    output cfg_valid, cfg_ratio, div_cnt,
    input  cfg_ready, cfg_err, div_en, div_ratio, div_load
  );
  modport slave (
    input  cfg_valid, cfg_ratio, div_cnt,
    output cfg_ready, cfg_err, div_en, div_ratio, div_load
  );
endinterface

// File: rtl/division_ctrl.sv
// Run/stop and ratio-change sequencer for one integer clock divider.
// Ratio changes land only on a divide-period boundary followed by a quiet gap.
module division_ctrl #(
  parameter int MAX_RATIO     = 16,
  parameter int DEFAULT_RATIO = 5,
  parameter int RATIO_W       = 5,
  parameter int CNT_W         = 4,
  parameter int GAP_CYC       = 2,
  parameter int TIMEOUT       = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run_req,
  division_ctrl_if.slave  cif,
  output logic            busy,
  output logic            to_err
);
  localparam logic [2:0] S_OFF   = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_LOAD  = 3'd4;

  localparam int GW = $clog2(GAP_CYC + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [2:0]         state;
  logic [RATIO_W-1:0] pending;
  logic               stop;
  logic [GW-1:0]      gap_cnt;
  logic [TW-1:0]      tmo_cnt;
  logic               en_q, load_q, err_q;
  logic [RATIO_W-1:0] ratio_q;
  logic               ready, accept, legal, tc;

  assign ready  = (state == S_OFF) || (state == S_RUN);
  assign accept = cif.cfg_valid && ready;
  assign legal  = (cif.cfg_ratio >= RATIO_W'(2)) && (cif.cfg_ratio <= RATIO_W'(MAX_RATIO));
  assign tc     = (RATIO_W'(cif.div_cnt) == (ratio_q - RATIO_W'(1)));
  assign busy   = (state == S_DRAIN) || (state == S_GAP) || (state == S_LOAD);

  assign cif.cfg_ready = ready;
  assign cif.cfg_err   = err_q;
  assign cif.div_en    = en_q;
  assign cif.div_ratio = ratio_q;
  assign cif.div_load  = load_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_OFF;
      pending <= RATIO_W'(DEFAULT_RATIO);
      ratio_q <= RATIO_W'(DEFAULT_RATIO);
      stop    <= 1'b0;
      gap_cnt <= '0;
      tmo_cnt <= '0;
      en_q    <= 1'b0;
      load_q  <= 1'b0;
      err_q   <= 1'b0;
      to_err  <= 1'b0;
    end else begin
      load_q <= 1'b0;
      // illegal ratios are still handshaken; they only raise the error pulse
      err_q  <= accept && !legal;
      case (state)
        S_OFF: begin
          if (accept && legal) begin
            pending <= cif.cfg_ratio;
            state   <= S_LOAD;
          end else if (run_req) begin
            en_q  <= 1'b1;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          // a ratio offer beats a simultaneous stop; the stop is seen after LOAD
          if (accept && legal) begin
            pending <= cif.cfg_ratio;
            stop    <= 1'b0;
            tmo_cnt <= '0;
            state   <= S_DRAIN;
          end else if (!run_req) begin
            stop    <= 1'b1;
            tmo_cnt <= '0;
            state   <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (tc || (tmo_cnt == TW'(TIMEOUT - 1))) begin
            if (!tc) to_err <= 1'b1;
            en_q    <= 1'b0;
            gap_cnt <= '0;
            state   <= S_GAP;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        S_GAP: begin
          if (gap_cnt == GW'(GAP_CYC - 1)) state <= stop ? S_OFF : S_LOAD;
          else gap_cnt <= gap_cnt + GW'(1);
        end
        S_LOAD: begin
          ratio_q <= pending;
          load_q  <= 1'b1;
          en_q    <= run_req;
          state   <= run_req ? S_RUN : S_OFF;
        end
        default: begin
          en_q  <= 1'b0;
          state <= S_OFF;
        end
      endcase
    end
  end
endmodule
